// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO sitting between the UART receiver and
// the CPU-bus register interface. First-word-fall-through: o_rdData always
// carries the registered head byte, and i_rdEn consumes it.
// Status (empty/full/count) is registered. o_overflow is sticky.
//
// Optional feature (macro UART_RX_FIFO_IRQ_EN): adds o_irq, the
// IRQ_THRESHOLD / IRQ_TIMEOUT parameters and a 16-bit idle timer. The default
// build (macro undefined) has none of these.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2    = 4
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    parameter int unsigned IRQ_THRESHOLD = 8,
    parameter int unsigned IRQ_TIMEOUT   = 3472
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_rxValid,
    input  logic [7:0]            i_rxData,
    input  logic                  i_rdEn,
    output logic [7:0]            o_rdData,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    input  logic                  i_clearOverflow
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    output logic                  o_irq
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);

    // Storage and state
    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  overflow_q, overflow_d;

    // Per-cycle handshake decisions
    logic                  pop_ok;
    logic                  wr_ok;
    logic                  ovf_set;

    // Accept/drop decisions: a pop only counts when something is stored; a
    // write into a full FIFO is only accepted alongside an accepted pop.
    always_comb begin
        pop_ok  = i_rdEn && !empty_q;
        wr_ok   = i_rxValid && (!full_q || pop_ok);
        ovf_set = i_rxValid && full_q && !pop_ok;
    end

    // Next-state for pointers, count, status flags and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (wr_ok) begin
            mem_d[wr_ptr_q] = i_rxData;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);

        // Head byte is looked up through the updated storage, so a byte
        // written this cycle at the new read pointer is visible next cycle.
        rd_data_d = mem_d[rd_ptr_d];

        // Set has priority over clear.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (i_clearOverflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Byte storage; contents need no reset.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_rdData   = rd_data_q;
    assign o_empty    = empty_q;
    assign o_full     = full_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [15:0]      TMO_LIMIT = 16'(IRQ_TIMEOUT);
    localparam logic [CNT_W-1:0] IRQ_LEVEL = CNT_W'(IRQ_THRESHOLD);

    logic [15:0] idle_q, idle_d;
    logic        irq_q, irq_d;

    // Idle timer restarts on any traffic or while empty, and saturates at the
    // timeout. The request is computed from next-state values so that it
    // lines up with the count it describes.
    always_comb begin
        if (wr_ok || pop_ok || empty_q) begin
            idle_d = '0;
        end else if (idle_q >= TMO_LIMIT) begin
            idle_d = TMO_LIMIT;
        end else begin
            idle_d = idle_q + 16'd1;
        end

        irq_d = (count_d >= IRQ_LEVEL) ||
                ((count_d != '0) && (idle_d >= TMO_LIMIT));
    end

    // Interrupt timer and request registers.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            idle_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            irq_q  <= irq_d;
        end
    end

    assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo. Stimulus pushes every byte it expects the
// FIFO to deliver; an independent monitor pops and compares whenever a pop is
// presented to a non-empty FIFO. Status outputs are checked inline.
module tb_uart_rx_fifo;

    localparam int unsigned DL2 = 4;

    logic           i_clk;
    logic           i_resetn;
    logic           i_rxValid;
    logic [7:0]     i_rxData;
    logic           i_rdEn;
    logic [7:0]     o_rdData;
    logic           o_empty;
    logic           o_full;
    logic [DL2:0]   o_count;
    logic           o_overflow;
    logic           i_clearOverflow;
`ifdef UART_RX_FIFO_IRQ_EN
    logic           o_irq;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  exp_q [$];

    uart_rx_fifo #(
        .DEPTH_LOG2(DL2)
`ifdef UART_RX_FIFO_IRQ_EN
        ,
        .IRQ_THRESHOLD(8),
        .IRQ_TIMEOUT(20)
`endif
    ) dut (
        .i_clk          (i_clk),
        .i_resetn       (i_resetn),
        .i_rxValid      (i_rxValid),
        .i_rxData       (i_rxData),
        .i_rdEn         (i_rdEn),
        .o_rdData       (o_rdData),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .i_clearOverflow(i_clearOverflow)
`ifdef UART_RX_FIFO_IRQ_EN
        ,
        .o_irq          (o_irq)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one cycle of inputs, let the edge take them, return 1 time unit later.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        i_rxValid       = v;
        i_rxData        = d;
        i_rdEn          = r;
        i_clearOverflow = c;
        @(posedge i_clk);
        #1;
        i_rxValid       = 1'b0;
        i_rdEn          = 1'b0;
        i_clearOverflow = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        exp_q.push_back(d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Monitor: inputs and outputs are both stable at the falling edge.
    always @(negedge i_clk) begin
        if (i_resetn && i_rdEn && !o_empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_pop: got 0x%0h expected no byte at %0t", o_rdData, $time);
            end else begin
                chk("sb_pop_data", int'(o_rdData), int'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_resetn        = 1'b0;
        i_rxValid       = 1'b0;
        i_rxData        = 8'h00;
        i_rdEn          = 1'b0;
        i_clearOverflow = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_full", int'(o_full), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_ovf", int'(o_overflow), 0);
        chk("rst_data", int'(o_rdData), 8'h00);
`ifdef UART_RX_FIFO_IRQ_EN
        chk("rst_irq", int'(o_irq), 0);
`endif
        i_resetn = 1'b1;
        @(posedge i_clk);
        #1;

        // Basic ordering and fall-through.
        wr(8'h41);
        chk("t1_empty_after_1", int'(o_empty), 0);
        chk("t1_head_after_1", int'(o_rdData), 8'h41);
        wr(8'h42);
        wr(8'h43);
        chk("t1_count", int'(o_count), 3);
        chk("t1_empty", int'(o_empty), 0);
        chk("t1_head", int'(o_rdData), 8'h41);
        pop_n(1);
        chk("t1_head_next", int'(o_rdData), 8'h42);
        pop_n(2);
        chk("t1_empty_end", int'(o_empty), 1);
        chk("t1_count_end", int'(o_count), 0);

        // Fill, overflow, drain.
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("t2_full", int'(o_full), 1);
        chk("t2_count", int'(o_count), 16);
        chk("t2_ovf_pre", int'(o_overflow), 0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("t2_ovf", int'(o_overflow), 1);
        chk("t2_count_ovf", int'(o_count), 16);
        chk("t2_head_ovf", int'(o_rdData), 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2_ovf_clr", int'(o_overflow), 0);
        pop_n(16);
        chk("t2_empty", int'(o_empty), 1);
        chk("t2_sb_left", exp_q.size(), 0);

        // Write with pop while full.
        for (int i = 0; i < 16; i++) wr(8'(i));
        exp_q.push_back(8'h55);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("t3_ovf", int'(o_overflow), 0);
        chk("t3_count", int'(o_count), 16);
        chk("t3_full", int'(o_full), 1);
        chk("t3_head", int'(o_rdData), 8'h01);
        pop_n(15);
        chk("t3_last_head", int'(o_rdData), 8'h55);
        chk("t3_count_last", int'(o_count), 1);
        pop_n(1);
        chk("t3_empty", int'(o_empty), 1);

        // Pop and write together on empty; pop alone on empty.
        exp_q.push_back(8'h7E);
        step(1'b1, 8'h7E, 1'b1, 1'b0);
        chk("t4_count", int'(o_count), 1);
        chk("t4_head", int'(o_rdData), 8'h7E);
        chk("t4_empty", int'(o_empty), 0);
        pop_n(1);
        pop_n(1);
        chk("t4_idle_count", int'(o_count), 0);
        chk("t4_idle_empty", int'(o_empty), 1);
        chk("t4_idle_ovf", int'(o_overflow), 0);

        // Pointer wrap with single write/pop pairs.
        for (int i = 0; i < 40; i++) begin
            wr(8'(8'h80 + i));
            chk("t5_count_one", int'(o_count), 1);
            pop_n(1);
            chk("t5_count_zero", int'(o_count), 0);
        end

        // Overflow set and clear in the same cycle: set wins.
        for (int i = 0; i < 16; i++) wr(8'(8'hC0 + i));
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("t6_ovf", int'(o_overflow), 1);
        step(1'b1, 8'hEF, 1'b0, 1'b1);
        chk("t6_ovf_setwins", int'(o_overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t6_ovf_clr", int'(o_overflow), 0);
        pop_n(16);
        chk("t6_sb_left", exp_q.size(), 0);

        // Asynchronous reset mid-operation.
        wr(8'h11);
        wr(8'h22);
        i_resetn = 1'b0;
        #1;
        chk("t7_rst_count", int'(o_count), 0);
        chk("t7_rst_empty", int'(o_empty), 1);
        chk("t7_rst_data", int'(o_rdData), 8'h00);
        exp_q.delete();
        @(posedge i_clk);
        #1;
        i_resetn = 1'b1;
        @(posedge i_clk);
        #1;

`ifdef UART_RX_FIFO_IRQ_EN
        // Idle-timeout interrupt with two bytes queued.
        wr(8'h01);
        wr(8'h02);
        for (int k = 0; k < 19; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t8_irq_before_tmo", int'(o_irq), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t8_irq_tmo", int'(o_irq), 1);
        pop_n(1);
        chk("t8_irq_pop1", int'(o_irq), 0);
        pop_n(1);
        chk("t8_irq_pop2", int'(o_irq), 0);
        // Threshold interrupt.
        for (int i = 0; i < 7; i++) wr(8'(8'h30 + i));
        chk("t8_irq_at7", int'(o_irq), 0);
        wr(8'h37);
        chk("t8_irq_at8", int'(o_irq), 1);
        wr(8'h38);
        i_resetn = 1'b0;
        #1;
        chk("t8_rst_irq", int'(o_irq), 0);
        chk("t8_rst_count", int'(o_count), 0);
        exp_q.delete();
        @(posedge i_clk);
        #1;
        i_resetn = 1'b1;
        @(posedge i_clk);
        #1;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
